// File: rtl/timestamp_pkg.sv
// ============================================================================
// Module   : timestamp_pkg
// Brief    : Shared constants, types and helpers for the timestamp engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timestamp_pkg;

  // USB frame numbering
  localparam int SOF_FRAME_W = 11;
  localparam int FRAME_EXT_W = 16;

  // Enabled cycles after a clear before the timestamp is trusted
  localparam int VALID_DELAY = 1024;

  // Increment constants in the default 8.16 fixed-point format
  localparam logic [23:0] INC_60M = 24'h01_0000;  // 1.0       : one tick per 60 MHz clk
  localparam logic [23:0] INC_1M  = 24'h00_0444;  // ~1/60     : 1 MHz timebase
  localparam logic [23:0] INC_1K  = 24'h00_0001;  // ~1/60000  : 1 kHz timebase

  // Per-cycle accumulator operation, in priority order
  typedef enum logic [1:0] {
    TS_OP_HOLD  = 2'd0,
    TS_OP_CLEAR = 2'd1,
    TS_OP_SYNC  = 2'd2,
    TS_OP_INC   = 2'd3
  } ts_op_e;

  // A new frame number lower than the previous one means the 11-bit count wrapped
  function automatic logic frame_wrapped(input logic [SOF_FRAME_W-1:0] cur,
                                         input logic [SOF_FRAME_W-1:0] prev);
    return (cur < prev);
  endfunction

endpackage

`default_nettype wire

// File: rtl/timestamp_engine_capture.sv
// ============================================================================
// Module   : ts_capture_channel
// Brief    : One event-capture channel: rising-edge detect, timestamp holding
//            register with valid/ready drain, sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_capture_channel #(
  parameter int TS_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            event_in,
  input  logic            cap_ready,
  input  logic            overrun_clear,
  input  logic [TS_W-1:0] ts_in,
  output logic            cap_valid,
  output logic [TS_W-1:0] cap_ts,
  output logic            cap_overrun
);

  logic            event_q, event_d;
  logic            valid_q, valid_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            ovr_q, ovr_d;
  logic            edge_w;
  logic            drain_w;

  // Next-state: edge capture, drain on handshake, overrun when the slot is busy
  always_comb begin
    edge_w  = event_in & ~event_q;
    drain_w = valid_q & cap_ready;
    event_d = event_in;
    valid_d = valid_q;
    ts_d    = ts_q;
    ovr_d   = ovr_q;

    if (overrun_clear) begin
      ovr_d = 1'b0;
    end

    if (edge_w) begin
      if (!valid_q || drain_w) begin
        ts_d    = ts_in;
        valid_d = 1'b1;
      end else begin
        // Holding register still owned by the consumer: drop and flag.
        // Placed after the clear so a coincident clear loses.
        ovr_d = 1'b1;
      end
    end else if (drain_w) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      event_q <= 1'b0;
      valid_q <= 1'b0;
      ts_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      event_q <= event_d;
      valid_q <= valid_d;
      ts_q    <= ts_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cap_valid   = valid_q;
  assign cap_ts      = ts_q;
  assign cap_overrun = ovr_q;

endmodule

`default_nettype wire

// File: rtl/timestamp_engine.sv
// ============================================================================
// Module   : timestamp_engine
// Brief    : Fractional-rate timestamp counter with millisecond tracking,
//            SOF frame extension / period measurement and per-channel event
//            capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timestamp_engine
  import timestamp_pkg::*;
#(
  parameter int TS_W   = 64,
  parameter int FRAC_W = 16,
  parameter int INC_W  = 8,
  parameter int NUM_CH = 4,
  parameter int SOFP_W = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     counter_enable,
  input  logic                     reset_counter,
  input  logic [INC_W+FRAC_W-1:0]  inc_value,
  input  logic [31:0]              ticks_per_ms,
  input  logic                     sync_enable,
  input  logic                     sync_pulse,
  input  logic [TS_W-1:0]          sync_value,
  input  logic                     sof_detected,
  input  logic [10:0]              sof_frame_num_in,
  input  logic [NUM_CH-1:0]        event_in,
  input  logic [NUM_CH-1:0]        cap_ready,
  input  logic [NUM_CH-1:0]        overrun_clear,
  output logic [TS_W-1:0]          timestamp,
  output logic [31:0]              timestamp_ms,
  output logic                     timestamp_valid,
  output logic [15:0]              sof_frame_num,
  output logic [SOFP_W-1:0]        sof_period,
  output logic                     sof_period_valid,
  output logic [NUM_CH-1:0]        cap_valid,
  output logic [NUM_CH*TS_W-1:0]   cap_ts,
  output logic [NUM_CH-1:0]        cap_overrun
);

  localparam int INC_TOT_W    = INC_W + FRAC_W;
  localparam int CARRY_W      = INC_W + 1;
  localparam int VCNT_W       = $clog2(VALID_DELAY + 1);
  localparam int FRAME_WRAP_W = FRAME_EXT_W - SOF_FRAME_W;

  // --------------------------------------------------------------------------
  // Timestamp accumulator state
  // --------------------------------------------------------------------------
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic [31:0]        ms_q, ms_d;
  logic [31:0]        ms_acc_q, ms_acc_d;
  logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
  logic               valid_q, valid_d;

  ts_op_e             op;
  logic [FRAC_W:0]    frac_sum;
  logic [CARRY_W-1:0] carry;
  logic [32:0]        ms_sum;

  // Decode the per-cycle operation by priority (rst handled in the flops)
  always_comb begin
    op = TS_OP_HOLD;
    if (reset_counter) begin
      op = TS_OP_CLEAR;
    end else if (sync_enable && sync_pulse) begin
      op = TS_OP_SYNC;
    end else if (counter_enable) begin
      op = TS_OP_INC;
    end
  end

  // Accumulator, millisecond and valid next-state
  always_comb begin
    // Integer amount added this cycle: integer part of the increment plus
    // the carry out of the fractional field.
    frac_sum = {1'b0, frac_q} + {1'b0, inc_value[FRAC_W-1:0]};
    carry    = {1'b0, inc_value[INC_TOT_W-1:FRAC_W]} + CARRY_W'(frac_sum[FRAC_W]);
    ms_sum   = {1'b0, ms_acc_q} + 33'(carry);

    ts_d     = ts_q;
    frac_d   = frac_q;
    ms_d     = ms_q;
    ms_acc_d = ms_acc_q;
    vcnt_d   = vcnt_q;
    valid_d  = valid_q;

    case (op)
      TS_OP_CLEAR: begin
        ts_d     = '0;
        frac_d   = '0;
        ms_d     = '0;
        ms_acc_d = '0;
        vcnt_d   = '0;
        valid_d  = 1'b0;
      end
      TS_OP_SYNC: begin
        // Millisecond count is deliberately kept across a sync load
        ts_d     = sync_value;
        frac_d   = '0;
        ms_acc_d = '0;
        valid_d  = 1'b1;
      end
      TS_OP_INC: begin
        ts_d   = ts_q + TS_W'(carry);
        frac_d = frac_sum[FRAC_W-1:0];
        // At most one millisecond per cycle; ticks_per_ms == 0 freezes tracking
        if (ticks_per_ms != 32'd0) begin
          if (ms_sum >= {1'b0, ticks_per_ms}) begin
            ms_acc_d = 32'(ms_sum - {1'b0, ticks_per_ms});
            ms_d     = ms_q + 32'd1;
          end else begin
            ms_acc_d = ms_sum[31:0];
          end
        end
        if (!valid_q) begin
          vcnt_d = vcnt_q + VCNT_W'(1);
          if (vcnt_q == VCNT_W'(VALID_DELAY - 1)) begin
            valid_d = 1'b1;
          end
        end
      end
      TS_OP_HOLD: begin
      end
    endcase
  end

  // Accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q     <= '0;
      frac_q   <= '0;
      ms_q     <= '0;
      ms_acc_q <= '0;
      vcnt_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      frac_q   <= frac_d;
      ms_q     <= ms_d;
      ms_acc_q <= ms_acc_d;
      vcnt_q   <= vcnt_d;
      valid_q  <= valid_d;
    end
  end

  assign timestamp       = ts_q;
  assign timestamp_ms    = ms_q;
  assign timestamp_valid = valid_q;

  // --------------------------------------------------------------------------
  // SOF frame extension and period measurement
  // --------------------------------------------------------------------------
  logic [SOF_FRAME_W-1:0]  frame_q, frame_d;
  logic [FRAME_WRAP_W-1:0] wrap_q, wrap_d;
  logic [SOFP_W-1:0]       pcnt_q, pcnt_d;
  logic [SOFP_W-1:0]       period_q, period_d;
  logic                    seen_q, seen_d;
  logic                    pvalid_q, pvalid_d;

  // SOF next-state: extend frame number, latch period, restart period count
  always_comb begin
    frame_d  = frame_q;
    wrap_d   = wrap_q;
    period_d = period_q;
    seen_d   = seen_q;
    pvalid_d = pvalid_q;
    pcnt_d   = pcnt_q;

    if (sof_detected) begin
      if (frame_wrapped(sof_frame_num_in, frame_q)) begin
        wrap_d = wrap_q + FRAME_WRAP_W'(1);
      end
      frame_d  = sof_frame_num_in;
      period_d = pcnt_q;
      pcnt_d   = SOFP_W'(1);
      seen_d   = 1'b1;
      if (seen_q) begin
        pvalid_d = 1'b1;
      end
    end else if (pcnt_q != {SOFP_W{1'b1}}) begin
      pcnt_d = pcnt_q + SOFP_W'(1);
    end
  end

  // SOF registers; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q  <= '0;
      wrap_q   <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      seen_q   <= 1'b0;
      pvalid_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      wrap_q   <= wrap_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      seen_q   <= seen_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign sof_frame_num    = {wrap_q, frame_q};
  assign sof_period       = period_q;
  assign sof_period_valid = pvalid_q;

  // --------------------------------------------------------------------------
  // Event capture channels, all sampling the registered timestamp
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ts_capture_channel #(
        .TS_W (TS_W)
      ) u_cap (
        .clk           (clk),
        .rst           (rst),
        .event_in      (event_in[i]),
        .cap_ready     (cap_ready[i]),
        .overrun_clear (overrun_clear[i]),
        .ts_in         (ts_q),
        .cap_valid     (cap_valid[i]),
        .cap_ts        (cap_ts[i*TS_W +: TS_W]),
        .cap_overrun   (cap_overrun[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_timestamp_engine.sv
// ============================================================================
// Module   : tb_timestamp_engine
// Brief    : Directed self-checking bench for timestamp_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timestamp_engine;

  localparam int TS_W   = 64;
  localparam int FRAC_W = 16;
  localparam int INC_W  = 8;
  localparam int NUM_CH = 4;
  localparam int SOFP_W = 20;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    counter_enable;
  logic                    reset_counter;
  logic [INC_W+FRAC_W-1:0] inc_value;
  logic [31:0]             ticks_per_ms;
  logic                    sync_enable;
  logic                    sync_pulse;
  logic [TS_W-1:0]         sync_value;
  logic                    sof_detected;
  logic [10:0]             sof_frame_num_in;
  logic [NUM_CH-1:0]       event_in;
  logic [NUM_CH-1:0]       cap_ready;
  logic [NUM_CH-1:0]       overrun_clear;
  logic [TS_W-1:0]         timestamp;
  logic [31:0]             timestamp_ms;
  logic                    timestamp_valid;
  logic [15:0]             sof_frame_num;
  logic [SOFP_W-1:0]       sof_period;
  logic                    sof_period_valid;
  logic [NUM_CH-1:0]       cap_valid;
  logic [NUM_CH*TS_W-1:0]  cap_ts;
  logic [NUM_CH-1:0]       cap_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timestamp_engine #(
    .TS_W   (TS_W),
    .FRAC_W (FRAC_W),
    .INC_W  (INC_W),
    .NUM_CH (NUM_CH),
    .SOFP_W (SOFP_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .counter_enable   (counter_enable),
    .reset_counter    (reset_counter),
    .inc_value        (inc_value),
    .ticks_per_ms     (ticks_per_ms),
    .sync_enable      (sync_enable),
    .sync_pulse       (sync_pulse),
    .sync_value       (sync_value),
    .sof_detected     (sof_detected),
    .sof_frame_num_in (sof_frame_num_in),
    .event_in         (event_in),
    .cap_ready        (cap_ready),
    .overrun_clear    (overrun_clear),
    .timestamp        (timestamp),
    .timestamp_ms     (timestamp_ms),
    .timestamp_valid  (timestamp_valid),
    .sof_frame_num    (sof_frame_num),
    .sof_period       (sof_period),
    .sof_period_valid (sof_period_valid),
    .cap_valid        (cap_valid),
    .cap_ts           (cap_ts),
    .cap_overrun      (cap_overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst              = 1'b1;
    counter_enable   = 1'b0;
    reset_counter    = 1'b0;
    inc_value        = '0;
    ticks_per_ms     = 32'd0;
    sync_enable      = 1'b0;
    sync_pulse       = 1'b0;
    sync_value       = '0;
    sof_detected     = 1'b0;
    sof_frame_num_in = '0;
    event_in         = '0;
    cap_ready        = '0;
    overrun_clear    = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_ts",      timestamp, 64'd0);
    check("rst_ms",      64'(timestamp_ms), 64'd0);
    check("rst_valid",   64'(timestamp_valid), 64'd0);
    check("rst_frame",   64'(sof_frame_num), 64'd0);
    check("rst_period",  64'(sof_period), 64'd0);
    check("rst_pvalid",  64'(sof_period_valid), 64'd0);
    check("rst_capv",    64'(cap_valid), 64'd0);
    check("rst_capovr",  64'(cap_overrun), 64'd0);
    check("rst_capts0",  cap_ts[63:0], 64'd0);

    // Integer rate 1.0, 600 ticks per ms (scaled-down millisecond)
    inc_value      = 24'h01_0000;
    ticks_per_ms   = 32'd600;
    counter_enable = 1'b1;
    tick(599);
    check("int_ts599",   timestamp, 64'd599);
    check("int_ms599",   64'(timestamp_ms), 64'd0);
    tick(1);
    check("int_ms600",   64'(timestamp_ms), 64'd1);
    tick(423);
    check("int_ts1023",  timestamp, 64'd1023);
    check("int_v1023",   64'(timestamp_valid), 64'd0);
    tick(1);
    check("int_ts1024",  timestamp, 64'd1024);
    check("int_v1024",   64'(timestamp_valid), 64'd1);
    tick(176);
    check("int_ts1200",  timestamp, 64'd1200);
    check("int_ms1200",  64'(timestamp_ms), 64'd2);

    // ticks_per_ms = 0 freezes millisecond tracking
    ticks_per_ms = 32'd0;
    tick(700);
    check("frz_ts",      timestamp, 64'd1900);
    check("frz_ms",      64'(timestamp_ms), 64'd2);

    // Fractional rate 0.25; reset_counter wins over the enable
    inc_value     = 24'h00_4000;
    reset_counter = 1'b1;
    tick(1);
    check("rc_ts",       timestamp, 64'd0);
    check("rc_ms",       64'(timestamp_ms), 64'd0);
    check("rc_valid",    64'(timestamp_valid), 64'd0);
    reset_counter = 1'b0;
    tick(3);
    check("frac_ts3",    timestamp, 64'd0);
    tick(1);
    check("frac_ts4",    timestamp, 64'd1);
    tick(396);
    check("frac_ts400",  timestamp, 64'd100);

    // Sync load: reset_counter wins, then alone, then wrap
    inc_value     = 24'h01_0000;
    sync_value    = 64'hFFFF_FFFF_FFFF_FFFE;
    sync_enable   = 1'b1;
    sync_pulse    = 1'b1;
    reset_counter = 1'b1;
    tick(1);
    check("syrc_ts",     timestamp, 64'd0);
    check("syrc_valid",  64'(timestamp_valid), 64'd0);
    reset_counter = 1'b0;
    tick(1);
    check("sync_ts",     timestamp, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sync_valid",  64'(timestamp_valid), 64'd1);
    sync_pulse = 1'b0;
    tick(1);
    check("sync_ts1",    timestamp, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(1);
    check("sync_wrap",   timestamp, 64'd0);
    check("sync_v2",     64'(timestamp_valid), 64'd1);

    // SOF: frames 2046, 2047, 0 with 600 then 300 cycles between strobes
    sof_detected     = 1'b1;
    sof_frame_num_in = 11'd2046;
    tick(1);
    sof_detected = 1'b0;
    check("sof1_frame",  64'(sof_frame_num), 64'h07FE);
    check("sof1_pvalid", 64'(sof_period_valid), 64'd0);
    tick(599);
    sof_detected     = 1'b1;
    sof_frame_num_in = 11'd2047;
    tick(1);
    sof_detected = 1'b0;
    check("sof2_frame",  64'(sof_frame_num), 64'h07FF);
    check("sof2_period", 64'(sof_period), 64'd600);
    check("sof2_pvalid", 64'(sof_period_valid), 64'd1);
    tick(299);
    sof_detected     = 1'b1;
    sof_frame_num_in = 11'd0;
    tick(1);
    sof_detected = 1'b0;
    check("sof3_frame",  64'(sof_frame_num), 64'h0800);
    check("sof3_period", 64'(sof_period), 64'd300);
    reset_counter = 1'b1;
    tick(1);
    reset_counter = 1'b0;
    check("sof_rc_frame", 64'(sof_frame_num), 64'h0800);
    check("sof_rc_pval",  64'(sof_period_valid), 64'd1);

    // Capture channel 0: overrun while full, drain+edge, set-wins
    // After the reset_counter above timestamp is 0 at this point.
    tick(2);                          // ts = 2
    event_in = 4'b0001;
    tick(1);                          // captured 2, ts = 3
    check("cap_v0",      64'(cap_valid), 64'h1);
    check("cap_ts0_a",   cap_ts[63:0], 64'd2);
    event_in = 4'b0000;
    tick(1);                          // ts = 4
    event_in = 4'b0001;
    tick(1);                          // dropped, ts = 5
    check("ovr_ts0",     cap_ts[63:0], 64'd2);
    check("ovr_flag",    64'(cap_overrun), 64'h1);
    event_in      = 4'b0000;
    overrun_clear = 4'b0001;
    tick(1);                          // ts = 6
    check("ovr_clr",     64'(cap_overrun), 64'h0);
    overrun_clear = 4'b0000;
    event_in      = 4'b0001;
    cap_ready     = 4'b0001;
    tick(1);                          // drain + reload with 6, ts = 7
    check("drn_ts0",     cap_ts[63:0], 64'd6);
    check("drn_v",       64'(cap_valid), 64'h1);
    check("drn_ovr",     64'(cap_overrun), 64'h0);
    event_in = 4'b0000;
    tick(1);                          // plain handshake, ts = 8
    check("hs_clear_v",  64'(cap_valid), 64'h0);
    cap_ready = 4'b0000;
    event_in  = 4'b0001;
    tick(1);                          // captured 8, ts = 9
    event_in = 4'b0000;
    tick(1);                          // ts = 10
    event_in      = 4'b0001;
    overrun_clear = 4'b0001;
    tick(1);                          // overrun set beats clear
    check("setwin_ovr",  64'(cap_overrun), 64'h1);
    check("setwin_ts0",  cap_ts[63:0], 64'd8);

    // All channels on the same edge
    event_in      = 4'b0000;
    overrun_clear = 4'b1111;
    cap_ready     = 4'b1111;
    reset_counter = 1'b1;
    tick(1);                          // ts = 0, holdings drained
    check("all_pre_v",   64'(cap_valid), 64'h0);
    check("all_pre_ovr", 64'(cap_overrun), 64'h0);
    reset_counter = 1'b0;
    overrun_clear = 4'b0000;
    cap_ready     = 4'b0000;
    tick(4);                          // ts = 4
    event_in = 4'b1111;
    tick(1);                          // all capture 4
    check("all_v",       64'(cap_valid), 64'hF);
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("all_ts%0d", i), cap_ts[i*TS_W +: TS_W], 64'd4);
    end

    // rst with captures pending discards them
    event_in  = 4'b0000;
    cap_ready = 4'b1111;
    rst       = 1'b1;
    tick(1);
    rst       = 1'b0;
    cap_ready = 4'b0000;
    check("rst2_capv",   64'(cap_valid), 64'h0);
    check("rst2_capts3", cap_ts[3*TS_W +: TS_W], 64'd0);
    check("rst2_frame",  64'(sof_frame_num), 64'd0);
    tick(1);
    check("rst2_capv_b", 64'(cap_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
